// File: rtl/tick_divider.sv
// Runtime-loadable clock divider with tick, square wave and
// a chain of aligned decimal-style cascade tick stages.
module tick_divider #(
    parameter int CNT_W       = 27,
    parameter int DEFAULT_DIV = 1000000,
    parameter int NUM_CASC    = 2,
    parameter int CASC_RATIO  = 10,
    parameter int CASC_W      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                clr,
    input  logic                div_ld,
    input  logic [CNT_W-1:0]    div_in,
    output logic [CNT_W-1:0]    cnt_out,
    output logic                tick,
    output logic                clk_out,
    output logic [NUM_CASC-1:0] casc_tick
);

    localparam logic [CASC_W-1:0] LAST = CASC_W'(CASC_RATIO - 1);

    logic [CNT_W-1:0]    div_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    term_val;
    logic                term;
    logic                base_evt;
    logic [CASC_W-1:0]   casc_q [NUM_CASC];
    logic [CASC_W-1:0]   casc_d [NUM_CASC];
    logic [NUM_CASC-1:0] casc_wrap;

    // Divisors 0 and 1 both mean "tick every enabled cycle"
    always_comb begin
        term_val = '0;
        if (div_q > CNT_W'(1))
            term_val = div_q - CNT_W'(1);
    end

    assign term     = (count_q == term_val);
    assign base_evt = en && !clr && !div_ld && term;

    // Carry ripples through stages so every wrap lands in the same cycle
    always_comb begin : casc_next
        logic carry;
        carry = base_evt;
        for (int k = 0; k < NUM_CASC; k++) begin
            casc_d[k]    = casc_q[k];
            casc_wrap[k] = 1'b0;
            if (carry) begin
                if (casc_q[k] == LAST) begin
                    casc_d[k]    = '0;
                    casc_wrap[k] = 1'b1;
                end else begin
                    casc_d[k] = casc_q[k] + CASC_W'(1);
                end
            end
            carry = casc_wrap[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q     <= CNT_W'(DEFAULT_DIV);
            count_q   <= '0;
            tick      <= 1'b0;
            clk_out   <= 1'b0;
            casc_tick <= '0;
            for (int k = 0; k < NUM_CASC; k++)
                casc_q[k] <= '0;
        end else if (clr) begin
            if (div_ld)
                div_q <= div_in;
            count_q   <= '0;
            tick      <= 1'b0;
            clk_out   <= 1'b0;
            casc_tick <= '0;
            for (int k = 0; k < NUM_CASC; k++)
                casc_q[k] <= '0;
        end else if (div_ld) begin
            div_q     <= div_in;
            count_q   <= '0;
            tick      <= 1'b0;
            casc_tick <= '0;
        end else if (en) begin
            if (term) begin
                count_q <= '0;
                tick    <= 1'b1;
                clk_out <= ~clk_out;
            end else begin
                count_q <= count_q + CNT_W'(1);
                tick    <= 1'b0;
            end
            casc_tick <= casc_wrap;
            for (int k = 0; k < NUM_CASC; k++)
                casc_q[k] <= casc_d[k];
        end else begin
            tick      <= 1'b0;
            casc_tick <= '0;
        end
    end

    assign cnt_out = count_q;

endmodule

// File: tb/tb_tick_divider.sv
// Directed bench for tick_divider with an event-counting
// reference model compared on every falling edge.
module tb_tick_divider;

    localparam int CNT_W = 27;
    localparam int DDIV  = 5;
    localparam int NC    = 2;
    localparam int R     = 10;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             clr;
    logic             div_ld;
    logic [CNT_W-1:0] div_in;
    logic [CNT_W-1:0] cnt_out;
    logic             tick;
    logic             clk_out;
    logic [NC-1:0]    casc_tick;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    // model state: divisor, count, tick, ticks since clear/reset
    longint m_d;
    longint m_cnt;
    bit     m_tick;
    longint m_ticks;
    bit [NC-1:0] m_casc;

    tick_divider #(
        .CNT_W(CNT_W), .DEFAULT_DIV(DDIV), .NUM_CASC(NC),
        .CASC_RATIO(R), .CASC_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .div_ld(div_ld), .div_in(div_in), .cnt_out(cnt_out),
        .tick(tick), .clk_out(clk_out), .casc_tick(casc_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        longint deff;
        longint pw;
        if (!reset) begin
            m_d = DDIV; m_cnt = 0; m_tick = 0;
            m_ticks = 0; m_casc = '0;
            return;
        end
        deff = (m_d <= 1) ? 1 : m_d;
        m_casc = '0;
        m_tick = 0;
        if (clr) begin
            if (div_ld) m_d = div_in;
            m_cnt = 0; m_ticks = 0;
        end else if (div_ld) begin
            m_d = div_in; m_cnt = 0;
        end else if (en) begin
            if (m_cnt == deff - 1) begin
                m_cnt = 0; m_tick = 1;
                m_ticks++;
                pw = 1;
                for (int k = 0; k < NC; k++) begin
                    pw = pw * R;
                    m_casc[k] = (m_ticks % pw == 0);
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on && reset) begin
                chk("m_cnt", cnt_out, m_cnt);
                chk("m_tick", tick, m_tick);
                chk("m_clk_out", clk_out, m_ticks % 2);
                chk("m_casc", casc_tick, m_casc);
            end
        end
    end

    task automatic edge1();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input int v);
        div_ld = 1; div_in = CNT_W'(v);
        edge1();
        div_ld = 0;
    endtask

    initial begin
        reset = 0; en = 1; clr = 0; div_ld = 0; div_in = '0;
        repeat (2) @(negedge clk);
        reset = 1;
        chk("reset_cnt", cnt_out, 0);
        chk("reset_clk_out", clk_out, 0);
        chk_on = 1;

        // default divisor 5, cascade 10/10
        for (int e = 1; e <= 1000; e++) begin
            edge1();
            if (e <= 15) begin
                chk("t1_cnt", cnt_out, e % 5);
                chk("t1_tick", tick, (e % 5) == 0);
                chk("t1_clk_out", clk_out, (e / 5) % 2);
            end
            chk("t2_casc", casc_tick,
                {1'(e % 500 == 0), 1'(e % 50 == 0)});
        end

        // divisor load mid-period
        repeat (2) edge1();
        chk("t3_pre_cnt", cnt_out, 2);
        load(3);
        chk("t3_ld_cnt", cnt_out, 0);
        chk("t3_ld_tick", tick, 0);
        for (int e = 1; e <= 3; e++) begin
            edge1();
            chk("t3_tick", tick, e == 3);
        end
        chk("t3_clk_out", clk_out, 1);
        load(0);
        chk("t3_d0_tick", tick, 0);
        for (int e = 1; e <= 4; e++) begin
            edge1();
            chk("t3_d0_tick", tick, 1);
            chk("t3_d0_clk", clk_out, e % 2 == 0);
        end

        // enable hold
        load(5);
        repeat (3) edge1();
        chk("t4_pre_cnt", cnt_out, 3);
        en = 0;
        for (int e = 0; e < 7; e++) begin
            edge1();
            chk("t4_hold_cnt", cnt_out, 3);
            chk("t4_hold_tick", tick, 0);
        end
        en = 1;
        edge1();
        chk("t4_tick_a", tick, 0);
        edge1();
        chk("t4_tick_b", tick, 1);

        // asynchronous reset mid-period
        load(9);
        repeat (3) edge1();
        #2 reset = 0;
        #1;
        chk("t5_cnt", cnt_out, 0);
        chk("t5_tick", tick, 0);
        chk("t5_clk_out", clk_out, 0);
        chk("t5_casc", casc_tick, 0);
        @(negedge clk);
        reset = 1;
        for (int e = 1; e <= 5; e++) begin
            edge1();
            chk("t5_tick_after", tick, e == 5);
        end

        // clear on terminal count
        repeat (4) edge1();
        chk("t6_pre_cnt", cnt_out, 4);
        chk("t6_pre_clk", clk_out, 1);
        clr = 1;
        edge1();
        clr = 0;
        chk("t6_cnt", cnt_out, 0);
        chk("t6_tick", tick, 0);
        chk("t6_clk_out", clk_out, 0);
        for (int e = 1; e <= 50; e++) begin
            edge1();
            chk("t6_tick_after", tick, e % 5 == 0);
            chk("t6_casc0", casc_tick[0], e == 50);
        end

        // clear together with load
        clr = 1; div_ld = 1; div_in = CNT_W'(4);
        edge1();
        clr = 0; div_ld = 0;
        chk("t7_cnt", cnt_out, 0);
        for (int e = 1; e <= 8; e++) begin
            edge1();
            chk("t7_tick", tick, e % 4 == 0);
        end

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_divider.md
Name: tick_divider

Overview:
- Parametrised successor to the stopwatch clock generator.
- Divides the system clock by a runtime-loadable divisor and emits a one-cycle tick plus a 50%-duty square-wave output.
- A chain of NUM_CASC decimal-style cascade stages produces slower aligned ticks, e.g. 10 ms -> 100 ms -> 1 s, for the stopwatch digit logic.
- All outputs are registered and synchronous to clk.

Parameters:
- CNT_W, 27: width of the base counter and of the divisor.
- DEFAULT_DIV, 1000000: divisor loaded at reset; 10 ms at 100 MHz.
- NUM_CASC, 2: number of cascade stages; must be >= 1.
- CASC_RATIO, 10: division ratio of each cascade stage; must be >= 2.
- CASC_W, 4: cascade counter width; must satisfy 2^CASC_W >= CASC_RATIO.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- en, input, 1: count enable.
- clr, input, 1: synchronous clear of all counters and outputs.
- div_ld, input, 1: load div_in into the divisor register.
- div_in, input, CNT_W: new divisor value.
- cnt_out, output, CNT_W: current base count.
- tick, output, 1: one-cycle pulse every D enabled cycles.
- clk_out, output, 1: square wave, toggles on each tick event.
- casc_tick, output, NUM_CASC: cascade stage pulses.

Behaviour:
- Reset (reset=0, asynchronous, no edge needed):
  - count=0, all cascade counters=0.
  - tick=0, clk_out=0, casc_tick=0.
  - Divisor register D=DEFAULT_DIV.
- Effective divisor: D_eff = 1 if D is 0 or 1; otherwise D_eff = D.
- Base counter, on each rising edge with en=1, clr=0, div_ld=0:
  - If count == D_eff-1: count<=0, tick<=1, clk_out<=~clk_out.
  - Otherwise: count<=count+1, tick<=0.
- Timing: the first tick is high in the cycle following the D_eff-th enabled edge after reset or clear, for exactly one cycle.
- Periods: tick period = D_eff enabled cycles; clk_out period = 2*D_eff. When D_eff=1, tick stays high continuously while en=1.
- en=0: count, cascade counters and clk_out hold; tick and casc_tick are 0 that cycle.
- div_ld=1 (with clr=0):
  - D<=div_in, count<=0, tick<=0, casc_tick<=0.
  - clk_out and the cascade counters hold.
  - Load beats a coincident terminal count: no tick and no toggle.
  - Load is independent of en.
- clr=1: highest synchronous priority.
  - count, cascade counters, tick, clk_out and casc_tick are all set to 0.
  - D is retained.
  - If div_ld is also 1, D is still loaded in the same cycle.
- Cascade stage k advances only on a stage-k input event:
  - Stage 0's input event is a base terminal-count event.
  - Stage k>0's input event is a stage k-1 wrap event.
  - On an input event: if stage count == CASC_RATIO-1, it wraps to 0 and casc_tick[k]<=1; otherwise it increments.
  - casc_tick[k] is 0 in every other cycle.
- Alignment: casc_tick[k] is asserted in the same cycle as tick and as every lower casc_tick that caused it (zero added latency). Cascade period = D_eff * CASC_RATIO^(k+1) enabled cycles.
- cnt_out is the live count register.
- Counter overflow is impossible because count never exceeds D_eff-1.

Test Plan:
1. DEFAULT_DIV=5, en=1 from release of reset -> tick high in the cycles after edges 5, 10, 15; clk_out rises at edge 5, falls at edge 10; cnt_out sequence 1,2,3,4,0.
2. DEFAULT_DIV=5, CASC_RATIO=10, NUM_CASC=2, en=1 for 1000 cycles:
   - casc_tick[0] fires every 50 cycles, coincident with tick.
   - casc_tick[1] fires first after edge 500, coincident with casc_tick[0] and tick.
3. At cnt_out=2 with D=5, pulse div_ld with div_in=3 -> cnt_out=0, no tick that cycle, next tick 3 enabled edges later. Then load div_in=0 -> tick constant 1 and clk_out toggles every cycle.
4. D=5, drop en at cnt_out=3 for 7 cycles -> cnt_out stays 3, tick=0; after re-enable the next tick comes 2 edges later.
5. Assert reset low mid-period, between clock edges -> all outputs 0 immediately. D reverts to DEFAULT_DIV, so after release the first tick comes 5 edges later even if div_in=9 was loaded before.
6. Assert clr on the terminal-count edge (cnt_out=4, D=5, clk_out=1) -> tick stays 0, clk_out=0, cnt_out=0, cascade counters 0; D still 5.
